fft_frame_tx: RTL and testbench
===============================

Name: fft_frame_tx

Overview:
- Frame transmitter that drives the serial input port (InEn/InR/InI) of the 64-point radix-4 FFT core.
- Accepts complex 8-bit samples from an upstream valid/ready stream and buffers one 64-sample frame.
- Replays the frame with the exact InEn framing the core requires: rising edge, one lead-in cycle, 64 samples, one tail cycle.
- Tracks the core's OutEn to learn when the core has returned to idle before launching the next frame.

Parameters:
- NUMP, 64, samples per frame (fixed by the FFT core).
- GAP_CYC, 2, minimum cycles fft_in_en is held low before each LEAD (min 2).
- WAIT_MAX, 2047, timeout in cycles waiting for fft_out_en to complete a pulse.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  upstream sample accepted when s_valid && s_ready.
- s_re  in  8  signed real part.
- s_im  in  8  signed imaginary part.
- s_last  in  1  marks the 64th sample of a frame.
- fft_in_en  out  1  to FFT InEn.
- fft_in_r  out  8  to FFT InR.
- fft_in_i  out  8  to FFT InI.
- fft_out_en  in  1  monitor of FFT OutEn.
- busy  out  1  high in LEAD/SEND/TAIL/WAIT.
- err  out  1  one-cycle error pulse.
- frames_sent  out  16  count of completed frames, wraps at 65535->0.

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - All outputs 0: fft_in_en, fft_in_r, fft_in_i, s_ready, busy, err, frames_sent.
  - Internal state: wr_cnt=0, rd_cnt=0, gap_cnt=0, state=IDLE.
- Buffer: 64 x 16-bit (re,im) register array; wr_cnt 0..64.
- s_ready is registered: 1 when wr_cnt<64 and state in {IDLE, WAIT}, else 0.
- Accept rule: on accept, buf[wr_cnt]<={s_re,s_im} and wr_cnt++.
- s_last checking:
  - s_last=1 with wr_cnt!=63, or s_last=0 with wr_cnt==63: err pulses next cycle, wr_cnt<=0, frame discarded, accepted sample dropped.
- gap_cnt: saturating at GAP_CYC; increments each IDLE cycle with fft_in_en=0; cleared on leaving IDLE.
- States:
  - IDLE: fft_in_en=0, data 0. If wr_cnt==64 and gap_cnt==GAP_CYC -> LEAD.
  - LEAD (1 cycle): fft_in_en=1, fft_in_r/i=0 (the core detects the edge here and does not capture data) -> SEND, rd_cnt=0.
  - SEND (64 cycles): fft_in_en=1, fft_in_r/i=buf[rd_cnt]; rd_cnt++. At rd_cnt==63 -> TAIL.
  - TAIL (1 cycle): fft_in_en=1, data 0 (the core needs InEn high on its count==64 cycle). wr_cnt<=0 -> WAIT, wait counter=0, seen_hi=0.
  - WAIT: fft_in_en=0.
    - fft_out_en=1 sets seen_hi.
    - fft_out_en=0 with seen_hi=1: frames_sent++ -> IDLE.
    - Wait counter reaching WAIT_MAX: err pulse -> IDLE (frames_sent unchanged).
- All fft_* outputs are registered. With the frame buffered and the gap satisfied:
  - cycle L: LEAD.
  - cycles L+1..L+64: samples 0..63.
  - cycle L+65: tail.
  - cycle L+66: fft_in_en=0.
- Minimum low time: fft_in_en is never high within GAP_CYC cycles after WAIT exits or after reset.
- Simultaneous events:
  - Accept and a frame-error decision on the same sample: error wins.
  - The 64th accept in IDLE with gap satisfied: LEAD on the following cycle.
  - WAIT timeout and the fft_out_en fall in the same cycle: treated as normal completion, no err.
- Reset mid-frame: next cycle all outputs are 0, the buffer is discarded, and the gap is enforced before the next LEAD.

Test Plan:
- Reset, push 64 samples re=k, im=-k with s_last on k=63, FFT model idle -> after 2 low cycles, LEAD with data 0, then in_r=0..63 and in_i=0..-63 in order, one tail cycle, then fft_in_en=0 and busy=1.
- Same frame, FFT model raises fft_out_en 786 cycles after the tail and holds it 66 cycles -> frames_sent=1 one cycle after the fall; the second buffered frame's LEAD comes no earlier than 2 cycles after the fall.
- Toggle s_valid randomly during LEAD/SEND/TAIL -> s_ready=0 throughout; exactly 64 samples accepted per frame.
- s_last asserted on sample 10 -> single err pulse, no LEAD, wr_cnt=0; the following good 64-sample frame transmits correctly.
- fft_out_en held 0 after a frame -> err pulse after 2047 WAIT cycles, return to IDLE, frames_sent unchanged.
- Assert rst while sending sample 30 -> fft_in_en=0 and data=0 the next cycle, s_ready=0; after release, a new full frame starts only after 2 low cycles.

Source files
------------

// File: rtl/fft_frame_tx.sv
// Buffers one 64-sample complex frame from a valid/ready stream and replays it
// into the FFT core's InEn/InR/InI port, then waits for the core's OutEn pulse.
module fft_frame_tx #(
  parameter int NUMP     = 64,
  parameter int GAP_CYC  = 2,
  parameter int WAIT_MAX = 2047
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_re,
  input  logic [7:0]  s_im,
  input  logic        s_last,
  output logic        fft_in_en,
  output logic [7:0]  fft_in_r,
  output logic [7:0]  fft_in_i,
  input  logic        fft_out_en,
  output logic        busy,
  output logic        err,
  output logic [15:0] frames_sent
);

  localparam int CW = $clog2(NUMP + 1);
  localparam int AW = $clog2(NUMP);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] FULL      = CW'(NUMP);
  localparam logic [CW-1:0] LAST_IDX  = CW'(NUMP - 1);
  localparam logic [GW-1:0] GAP_DONE  = GW'(GAP_CYC);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

  typedef enum logic [2:0] {IDLE, LEAD, SEND, TAIL, WAIT} state_t;

  state_t          state, state_nxt;
  logic [15:0]     frame_buf [NUMP];
  logic [CW-1:0]   wr_cnt, wr_nxt;
  logic [CW-1:0]   rd_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [WW-1:0]   wait_cnt;
  logic            seen_hi;
  logic            accept, frame_err, wait_done, wait_expired, send_data;

  // Next-state values are computed up front so that s_ready and the LEAD
  // decision can react to the 64th accept without a one-cycle bubble.
  always_comb begin
    accept       = s_valid && s_ready;
    frame_err    = accept && (s_last != (wr_cnt == LAST_IDX));
    wait_done    = (state == WAIT) && seen_hi && !fft_out_en;
    wait_expired = (state == WAIT) && !wait_done && (wait_cnt == WAIT_LAST);
    send_data    = (state == LEAD) || ((state == SEND) && (rd_cnt != FULL));

    wr_nxt = wr_cnt;
    if ((state == TAIL) || frame_err)
      wr_nxt = '0;
    else if (accept)
      wr_nxt = wr_cnt + 1'b1;

    state_nxt = state;
    unique case (state)
      IDLE: if ((wr_nxt == FULL) && (gap_cnt == GAP_DONE)) state_nxt = LEAD;
      LEAD: state_nxt = SEND;
      SEND: if (rd_cnt == FULL) state_nxt = TAIL;
      TAIL: state_nxt = WAIT;
      WAIT: if (wait_done || wait_expired) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && !frame_err)
      frame_buf[wr_cnt[AW-1:0]] <= {s_re, s_im};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      gap_cnt     <= '0;
      wait_cnt    <= '0;
      seen_hi     <= 1'b0;
      s_ready     <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      fft_in_en   <= 1'b0;
      fft_in_r    <= '0;
      fft_in_i    <= '0;
      frames_sent <= '0;
    end else begin
      state     <= state_nxt;
      wr_cnt    <= wr_nxt;
      s_ready   <= (wr_nxt < FULL) && ((state_nxt == IDLE) || (state_nxt == WAIT));
      busy      <= (state_nxt != IDLE);
      err       <= frame_err || wait_expired;
      fft_in_en <= (state_nxt == LEAD) || (state_nxt == SEND) || (state_nxt == TAIL);

      // LEAD preloads sample 0 so the samples land on the cycles after the edge.
      if (send_data) begin
        {fft_in_r, fft_in_i} <= frame_buf[rd_cnt[AW-1:0]];
        rd_cnt               <= rd_cnt + 1'b1;
      end else begin
        fft_in_r <= '0;
        fft_in_i <= '0;
        rd_cnt   <= '0;
      end

      if (state_nxt != IDLE)
        gap_cnt <= '0;
      else if ((state == IDLE) && (gap_cnt != GAP_DONE))
        gap_cnt <= gap_cnt + 1'b1;

      if (state == TAIL) begin
        wait_cnt <= '0;
        seen_hi  <= 1'b0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (fft_out_en)
          seen_hi <= 1'b1;
      end

      if (wait_done)
        frames_sent <= frames_sent + 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_frame_tx.sv
// Randomized bench for fft_frame_tx: a frame-level model predicts the replayed
// bursts, error pulses and completed-frame count, with a simple FFT OutEn model.
module tb_fft_frame_tx;

  localparam int NUMP     = 64;
  localparam int GAP_CYC  = 2;
  localparam int WAIT_MAX = 2047;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        fft_out_en = 1'b0;
  logic [7:0]  s_re = '0;
  logic [7:0]  s_im = '0;
  logic        s_ready, fft_in_en, busy, err;
  logic [7:0]  fft_in_r, fft_in_i;
  logic [15:0] frames_sent;

  fft_frame_tx #(.NUMP(NUMP), .GAP_CYC(GAP_CYC), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_re(s_re), .s_im(s_im), .s_last(s_last),
    .fft_in_en(fft_in_en), .fft_in_r(fft_in_r), .fft_in_i(fft_in_i),
    .fft_out_en(fft_out_en), .busy(busy), .err(err), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] exp_q[$];
  logic [15:0] mbuf[$];
  logic [15:0] cur [NUMP];
  int mcount = 0;
  int exp_frames_sent = 0;
  int exp_errs = 0;
  int err_seen = 0;
  int quiet_ref = 0;
  bit wait_open = 0;
  int wait_kind = 0;
  int last_accept = -100;
  bit idle_fill = 0;
  int fft_mode = 0;
  int resp_delay = 786;
  int rise_at = -1, fall_at = -1, timeout_at = -1;
  int rst_at_sample = -1;
  bit rst_pending = 0;
  bit rst_event_done = 0;
  int timeouts = 0;
  bit in_burst = 0;
  int blen = 0, data_bad = 0, ready_hi = 0, busy_lo = 0;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pushes n samples; s_last is raised on sample last_at. The model follows the
  // frame rules: a misplaced or missing s_last discards the partial frame.
  task automatic applyStimulus(input int n, input int last_at, input bit ramp);
    int k = 0;
    int guard = 0;
    bit pend_err = 0;
    logic [7:0] re, im;
    while (k < n) begin
      @(negedge clk);
      if (pend_err) begin
        checkOutput("frame_err_pulse", 32'(err), 1);
        pend_err = 0;
      end
      re = ramp ? 8'(k) : 8'($urandom);
      im = ramp ? 8'(-k) : 8'($urandom);
      s_re = re;
      s_im = im;
      s_last = (k == last_at);
      s_valid = ($urandom_range(0, 3) != 0);
      if (s_valid && s_ready) begin
        if (s_last != (mcount == NUMP - 1)) begin
          exp_errs++;
          pend_err = 1;
          mcount = 0;
          mbuf.delete();
        end else begin
          mbuf.push_back({re, im});
          mcount++;
          if (mcount == NUMP) begin
            foreach (mbuf[j]) exp_q.push_back(mbuf[j]);
            mbuf.delete();
            mcount = 0;
            last_accept = cyc;
            idle_fill = !wait_open && !in_burst && (cyc - quiet_ref > 10);
          end
        end
        k++;
        guard = 0;
      end else begin
        guard++;
        if (guard > 5000) begin
          checkOutput("ready_timeout", 0, 1);
          s_valid = 0;
          return;
        end
      end
    end
    @(negedge clk);
    s_valid = 0;
    s_last = 0;
    if (pend_err) checkOutput("frame_err_pulse", 32'(err), 1);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || in_burst || wait_open) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) checkOutput("idle_timeout", 0, 1);
  endtask

  // Burst monitor, FFT OutEn model and mid-frame reset injection.
  always @(negedge clk) begin
    if (err) err_seen++;
    if (rst_pending) begin
      checkOutput("rst_in_en", 32'(fft_in_en), 0);
      checkOutput("rst_data", 32'({fft_in_r, fft_in_i}), 0);
      checkOutput("rst_ready", 32'(s_ready), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      rst = 0;
      rst_pending = 0;
      quiet_ref = cyc;
      in_burst = 0;
      wait_open = 0;
      exp_frames_sent = 0;
      rst_event_done = 1;
    end else if (fft_in_en === 1'b1) begin
      if (!in_burst) begin
        in_burst = 1;
        blen = 0; data_bad = 0; ready_hi = 0; busy_lo = 0;
        checkOutput("gap_before_lead", 32'(cyc - quiet_ref > GAP_CYC), 1);
        if (idle_fill) checkOutput("lead_after_last_accept", cyc, last_accept + 1);
        idle_fill = 0;
        if (exp_q.size() < NUMP) begin
          checkOutput("unexpected_frame", exp_q.size(), NUMP);
          foreach (cur[j]) cur[j] = '0;
        end else begin
          foreach (cur[j]) cur[j] = exp_q.pop_front();
        end
      end
      if (blen == 0 || blen == NUMP + 1) begin
        if ({fft_in_r, fft_in_i} !== 16'h0) data_bad++;
      end else if (blen <= NUMP) begin
        if ({fft_in_r, fft_in_i} !== cur[blen-1]) data_bad++;
      end
      if (s_ready) ready_hi++;
      if (!busy) busy_lo++;
      blen++;
      if (rst_at_sample >= 0 && blen == rst_at_sample + 2) begin
        rst = 1;
        rst_at_sample = -1;
        rst_pending = 1;
      end
    end else if (in_burst) begin
      in_burst = 0;
      checkOutput("burst_len", blen, NUMP + 2);
      checkOutput("burst_data_errs", data_bad, 0);
      checkOutput("ready_low_in_burst", ready_hi, 0);
      checkOutput("busy_in_burst", busy_lo, 0);
      checkOutput("wait_busy", 32'(busy), 1);
      checkOutput("wait_ready", 32'(s_ready), 1);
      checkOutput("wait_data", 32'({fft_in_r, fft_in_i}), 0);
      wait_open = 1;
      wait_kind = fft_mode;
      if (fft_mode == 0) begin
        rise_at = cyc + resp_delay;
        fall_at = rise_at + 66;
        resp_delay = $urandom_range(0, 900);
      end else begin
        timeout_at = cyc + WAIT_MAX;
      end
    end else if (wait_open && wait_kind == 0 && cyc == fall_at + 1) begin
      exp_frames_sent = (exp_frames_sent + 1) & 16'hFFFF;
      checkOutput("frames_sent_after_fall", 32'(frames_sent), exp_frames_sent);
      checkOutput("idle_busy", 32'(busy), 0);
      quiet_ref = fall_at;
      wait_open = 0;
    end else if (wait_open && wait_kind == 1 && cyc == timeout_at - 1) begin
      checkOutput("no_early_timeout", 32'(err), 0);
    end else if (wait_open && wait_kind == 1 && cyc == timeout_at) begin
      exp_errs++;
      checkOutput("timeout_err", 32'(err), 1);
      checkOutput("timeout_frames_sent", 32'(frames_sent), exp_frames_sent);
      checkOutput("timeout_busy", 32'(busy), 0);
      quiet_ref = timeout_at - 1;
      wait_open = 0;
      timeouts++;
    end
    fft_out_en = wait_open && (wait_kind == 0) && (cyc >= rise_at) && (cyc < fall_at);
  end

  initial begin
    rst = 1;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_en", 32'(fft_in_en), 0);
    checkOutput("reset_data", 32'({fft_in_r, fft_in_i}), 0);
    checkOutput("reset_ready", 32'(s_ready), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_err", 32'(err), 0);
    checkOutput("reset_frames_sent", 32'(frames_sent), 0);
    rst = 0;
    quiet_ref = cyc;

    // Ramp frame then a random frame buffered while the core is busy.
    applyStimulus(NUMP, NUMP - 1, 1'b1);
    applyStimulus(NUMP, NUMP - 1, 1'b0);
    // Early s_last discards the partial frame; a good frame follows.
    applyStimulus(11, 10, 1'b0);
    applyStimulus(NUMP, NUMP - 1, 1'b0);
    waitIdle(8000);

    // Core never answers: WAIT must time out without counting a frame.
    fft_mode = 1;
    applyStimulus(NUMP, NUMP - 1, 1'b0);
    waitIdle(4000);
    fft_mode = 0;
    checkOutput("timeouts_seen", timeouts, 1);

    // Reset while sample 30 is on the bus, then a fresh frame.
    rst_at_sample = 30;
    applyStimulus(NUMP, NUMP - 1, 1'b0);
    begin
      int n = 0;
      while (!rst_event_done && n < 1000) begin
        @(negedge clk);
        n++;
      end
      if (!rst_event_done) checkOutput("reset_inject_timeout", 0, 1);
    end
    exp_q.delete();
    applyStimulus(NUMP, NUMP - 1, 1'b1);
    waitIdle(4000);

    repeat (4) @(negedge clk);
    checkOutput("err_pulse_count", err_seen, exp_errs);
    checkOutput("frames_sent_final", 32'(frames_sent), exp_frames_sent);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
